// File: rtl/pc_fetch_unit_if.sv
// pc_fetch_unit_if: instruction-memory fetch handshake
//   req   fetch request, held until ready
//   addr  fetch address
//   ready memory returns rdata this cycle
//   rdata fetched instruction word
interface pc_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ready;
  logic [31:0] rdata;
  modport master (output req, addr, input ready, rdata);
  modport slave (input req, addr, output ready, rdata);
endinterface

// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction fetch for the MIPS core
//   clk/rst            clock, synchronous active-low reset
//   imem               fetch handshake to instruction memory (master)
//   instr/opcode/func  latched instruction and its fields for the controller
//   instr_valid        instruction is stable and executing
//   exec_done          last execute cycle; pc_src/pc_jump/jump_sel/branch_imm/jr_addr sampled then
//   pc/pc_plus4        current instruction address and its successor
//   misalign_err       sticky flag: a computed next pc was not word-aligned
//   retired_count      number of completed instructions
module pc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  pc_fetch_unit_if.master    imem,
  output logic [31:0]        instr,
  output logic [5:0]         opcode,
  output logic [5:0]         func,
  output logic               instr_valid,
  input  logic               exec_done,
  input  logic               pc_src,
  input  logic               pc_jump,
  input  logic               jump_sel,
  input  logic [31:0]        branch_imm,
  input  logic [31:0]        jr_addr,
  output logic [31:0]        pc,
  output logic [31:0]        pc_plus4,
  output logic               misalign_err,
  output logic [31:0]        retired_count
);
  typedef enum logic [1:0] {IDLE, FETCH, ISSUE, ERROR} state_t;
  state_t state, state_nx;
  logic [31:0] next_pc;
  logic retire;
  assign pc_plus4 = pc + 32'd4;
  assign opcode = instr[31:26];
  assign func = instr[5:0];
  assign imem.addr = pc;
  assign retire = (state == ISSUE) && exec_done;
  // jumps outrank branches; J-type keeps the top nibble of pc+4
  assign next_pc = pc_jump ? (jump_sel ? {pc_plus4[31:28], instr[25:0], 2'b00} : jr_addr)
                 : pc_src ? pc_plus4 + (branch_imm << 2) : pc_plus4;
  always_comb begin
    state_nx = state;
    imem.req = 1'b0;
    instr_valid = 1'b0;
    imem.req = state == FETCH;
    instr_valid = state == ISSUE;
    state_nx = state == IDLE  ? FETCH
             : state == FETCH ? (imem.ready ? ISSUE : FETCH)
             : state == ISSUE ? (exec_done ? ((|next_pc[1:0]) ? ERROR : FETCH) : ISSUE)
             : ERROR;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      pc <= RESET_PC;
      instr <= 32'h0;
      retired_count <= 32'h0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == FETCH && imem.ready) instr <= imem.rdata;
      if (retire) retired_count <= retired_count + 32'd1;
      // a misaligned target is not committed; pc keeps the faulting instruction
      if (retire && (|next_pc[1:0])) misalign_err <= 1'b1;
      if (retire && !(|next_pc[1:0])) pc <= next_pc;
    end
  end
endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;
  logic clk, rst;
  logic [31:0] instr, pc, pc_plus4, retired_count, branch_imm, jr_addr;
  logic [5:0] opcode, func;
  logic instr_valid, exec_done, pc_src, pc_jump, jump_sel, misalign_err;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;
  exp_t q[$];
  pc_fetch_unit_if bus();
  pc_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
    .clk(clk), .rst(rst), .imem(bus), .instr(instr), .opcode(opcode), .func(func),
    .instr_valid(instr_valid), .exec_done(exec_done), .pc_src(pc_src), .pc_jump(pc_jump),
    .jump_sel(jump_sel), .branch_imm(branch_imm), .jr_addr(jr_addr), .pc(pc),
    .pc_plus4(pc_plus4), .misalign_err(misalign_err), .retired_count(retired_count)
  );
  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask
  // monitor: each new issue pops the expected pc/instruction
  initial begin
    logic prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (instr_valid === 1'b1 && !prev_v) begin
        if (q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_issue: pc %h issued, required none", pc);
        end else begin
          e = q.pop_front();
          check("issue_pc", pc, e.pc);
          check("issue_instr", instr, e.instr);
          check("issue_opcode", 32'(opcode), 32'(e.instr[31:26]));
          check("issue_func", 32'(func), 32'(e.instr[5:0]));
        end
      end
      prev_v = instr_valid === 1'b1;
    end
  end
  task automatic push(input logic [31:0] p, input logic [31:0] w);
    exp_t e;
    e.pc = p;
    e.instr = w;
    q.push_back(e);
  endtask
  task automatic clear_ctrl();
    exec_done = 0; pc_src = 0; pc_jump = 0; jump_sel = 0; branch_imm = 0; jr_addr = 0;
  endtask
  // serve one fetch (optionally late, with ignored exec_done pulses), then execute it
  task automatic run_instr(input logic [31:0] word, input logic ps, input logic pj, input logic js,
                           input logic [31:0] imm, input logic [31:0] jr, input int rdy_dly, input int done_dly);
    logic [31:0] a, r;
    int n;
    n = 0;
    while (bus.req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (bus.req !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL fetch_timeout: imem_req %b after %0d cycles, required 1", bus.req, n);
      return;
    end
    a = bus.addr;
    r = retired_count;
    for (int i = 0; i < rdy_dly; i++) begin
      bus.ready = 0; exec_done = 1; pc_jump = 1; jump_sel = 0; jr_addr = 32'h44;
      @(negedge clk);
      check("fetch_hold_req", 32'(bus.req), 32'd1);
      check("fetch_hold_addr", bus.addr, a);
      check("fetch_hold_retired", retired_count, r);
    end
    clear_ctrl();
    bus.ready = 1;
    bus.rdata = word;
    @(negedge clk);
    for (int i = 0; i < done_dly; i++) begin
      bus.ready = 1;
      bus.rdata = ~word;
      @(negedge clk);
      check("issue_hold_instr", instr, word);
      check("issue_hold_valid", 32'(instr_valid), 32'd1);
    end
    bus.ready = 0;
    pc_src = ps; pc_jump = pj; jump_sel = js; branch_imm = imm; jr_addr = jr; exec_done = 1;
    @(negedge clk);
    clear_ctrl();
  endtask
  initial begin
    rst = 0;
    bus.ready = 0;
    bus.rdata = 0;
    clear_ctrl();
    repeat (2) @(negedge clk);
    check("rst_req", 32'(bus.req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_pc", pc, 32'h100);
    check("rst_instr", instr, 32'h0);
    check("rst_retired", retired_count, 32'h0);
    check("rst_misalign", 32'(misalign_err), 32'd0);
    // back-to-back sequential fetches at minimum CPI
    rst = 1; bus.ready = 1; bus.rdata = 32'h0000_0020; exec_done = 1;
    push(32'h100, 32'h20); push(32'h104, 32'h20); push(32'h108, 32'h20);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) check("first_fetch_addr", bus.addr, 32'h100);
      check("alt_valid", 32'(instr_valid), 32'(i % 2));
      check("alt_req", 32'(bus.req), 32'((i + 1) % 2));
    end
    bus.ready = 0;
    @(negedge clk);
    check("seq_retired", retired_count, 32'd3);
    check("seq_next_addr", bus.addr, 32'h10c);
    exec_done = 0;
    // JR to 0x200, branch back 2 words, return, branch forward 3 words
    push(32'h10c, 32'h0000_0008);
    run_instr(32'h0000_0008, 0, 1, 0, 0, 32'h200, 0, 0);
    push(32'h200, 32'h1000_FFFE);
    run_instr(32'h1000_FFFE, 1, 0, 0, 32'hFFFF_FFFE, 0, 0, 1);
    push(32'h1FC, 32'h0000_0008);
    run_instr(32'h0000_0008, 0, 1, 0, 0, 32'h200, 2, 0);
    push(32'h200, 32'h1000_0003);
    run_instr(32'h1000_0003, 1, 0, 0, 32'h3, 0, 0, 0);
    push(32'h210, 32'h0000_0008);
    run_instr(32'h0000_0008, 0, 1, 0, 0, 32'h3000_0010, 0, 0);
    // J-type, then J-type with a simultaneous branch
    push(32'h3000_0010, 32'h0800_0040);
    run_instr(32'h0800_0040, 0, 1, 1, 0, 0, 0, 0);
    push(32'h3000_0100, 32'h0800_0040);
    run_instr(32'h0800_0040, 1, 1, 1, 32'h5, 0, 0, 0);
    // late memory with exec_done pulses during fetch
    push(32'h3000_0100, 32'h0000_0020);
    run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 5, 2);
    check("retired_after_delay", retired_count, 32'd11);
    // misaligned JR traps
    push(32'h3000_0104, 32'h0000_0008);
    run_instr(32'h0000_0008, 0, 1, 0, 0, 32'h0000_0403, 0, 0);
    for (int i = 0; i < 3; i++) begin
      bus.ready = 1;
      @(negedge clk);
      check("err_req", 32'(bus.req), 32'd0);
      check("err_valid", 32'(instr_valid), 32'd0);
      check("err_misalign", 32'(misalign_err), 32'd1);
      check("err_pc", pc, 32'h3000_0104);
    end
    check("err_retired", retired_count, 32'd12);
    check("err_pc_plus4", pc_plus4, 32'h3000_0108);
    bus.ready = 0;
    rst = 0;
    @(negedge clk);
    rst = 1;
    check("rst2_req", 32'(bus.req), 32'd0);
    check("rst2_misalign", 32'(misalign_err), 32'd0);
    check("rst2_retired", retired_count, 32'h0);
    check("rst2_pc", pc, 32'h100);
    check("rst2_instr", instr, 32'h0);
    push(32'h100, 32'h0000_0020);
    run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    // reset on the same edge as a completing fetch
    check("pre_rst_fetch_pc", pc, 32'h104);
    bus.ready = 1;
    bus.rdata = 32'hDEAD_BEEF;
    rst = 0;
    @(negedge clk);
    rst = 1;
    bus.ready = 0;
    check("rst_fetch_instr", instr, 32'h0);
    check("rst_fetch_req", 32'(bus.req), 32'd0);
    check("rst_fetch_valid", 32'(instr_valid), 32'd0);
    check("rst_fetch_pc", pc, 32'h100);
    // pc wraps through the top of the address space
    push(32'h100, 32'h0000_0008);
    run_instr(32'h0000_0008, 0, 1, 0, 0, 32'hFFFF_FFFC, 0, 0);
    check("wrap_pc_plus4", pc_plus4, 32'h0);
    push(32'hFFFF_FFFC, 32'h0000_0020);
    run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    push(32'h0, 32'h0000_0020);
    run_instr(32'h0000_0020, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    check("final_retired", retired_count, 32'd3);
    check("final_pc", pc, 32'h4);
    check("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
